logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe.sv | 84 ++++++++
 tb/tb_logic_unit_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined WIDTH-bit bitwise logic unit with valid/ready handshake
//   Ports: clk, rst (async, active-high)
//          in_valid/in_ready/in_op/in_a/in_b   - input beat (op: AND,OR,XOR,NAND,NOR,XNOR,ANDN,PASSA)
//          out_valid/out_ready/out_y/out_op    - result beat, from the last stage
//          busy                                - any stage holds a valid beat
//          out_zero/out_parity                 - result flags, only with LOGIC_UNIT_PIPE_FLAGS_EN defined
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
  output logic             busy
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  localparam int FW = 2;
`else
  localparam int FW = 0;
`endif
  localparam int DW = FW + 3 + WIDTH;
  logic [STAGES-1:0] v_q, v_d, v_in, adv, ld;
  logic [DW-1:0]     d_q [STAGES];
  logic [DW-1:0]     d_in [STAGES];
  logic [DW-1:0]     d0;
  logic [WIDTH-1:0]  y_d;
  logic              accept;
  assign accept   = in_valid && in_ready;
  assign in_ready = adv[0];
  always_comb begin
    y_d = in_op == 3'd0 ? in_a & in_b    :
          in_op == 3'd1 ? in_a | in_b    :
          in_op == 3'd2 ? in_a ^ in_b    :
          in_op == 3'd3 ? ~(in_a & in_b) :
          in_op == 3'd4 ? ~(in_a | in_b) :
          in_op == 3'd5 ? ~(in_a ^ in_b) :
          in_op == 3'd6 ? in_a & ~in_b   : in_a;
  end
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  assign d0 = {~|y_d, ^y_d, in_op, y_d};
  assign {out_zero, out_parity, out_op, out_y} = d_q[STAGES-1];
`else
  assign d0 = {in_op, y_d};
  assign {out_op, out_y} = d_q[STAGES-1];
`endif
  // A stage advances unless it and every stage after it is full while the sink stalls;
  // this is the recursive bubble-collapse rule flattened to avoid a combinational chain.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign adv[i] = out_ready || !(&v_q[STAGES-1:i]);
    if (i == 0) begin : g_first
      assign d_in[i] = d0;
    end else begin : g_rest
      assign d_in[i] = d_q[i-1];
    end
  end
  assign v_in = (v_q << 1) | STAGES'(accept);
  // Data only loads with a valid beat, so idle inputs (even X) never reach the registers.
  assign ld  = adv & v_in;
  assign v_d = (adv & v_in) | (~adv & v_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) d_q[s] <= '0;
    end else begin
      v_q <= v_d;
      for (int s = 0; s < STAGES; s++) if (ld[s]) d_q[s] <= d_in[s];
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign busy      = |v_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized and directed checks of logic_unit_pipe against a queue model
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [2:0] in_op = '0, out_op;
  logic [7:0] in_a = '0, in_b = '0, out_y;

  logic       i1_valid = 1'b0, i1_ready, o1_valid, o1_busy;
  logic [2:0] i1_op = '0, o1_op;
  logic [0:0] i1_a = '0, i1_b = '0, o1_y;

  logic        i4_valid = 1'b0, i4_ready, o4_valid, o4_busy;
  logic [2:0]  i4_op = '0, o4_op;
  logic [31:0] i4_a = '0, i4_b = '0, o4_y;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  logic z8, p8, z1, p1, z4, p4;
`endif

  logic_unit_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_op(out_op), .busy(busy)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    , .out_zero(z8), .out_parity(p8)
`endif
  );
  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(i1_valid), .in_ready(i1_ready), .in_op(i1_op),
    .in_a(i1_a), .in_b(i1_b), .out_valid(o1_valid), .out_ready(1'b1),
    .out_y(o1_y), .out_op(o1_op), .busy(o1_busy)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    , .out_zero(z1), .out_parity(p1)
`endif
  );
  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(i4_valid), .in_ready(i4_ready), .in_op(i4_op),
    .in_a(i4_a), .in_b(i4_b), .out_valid(o4_valid), .out_ready(1'b1),
    .out_y(o4_y), .out_op(o4_op), .busy(o4_busy)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    , .out_zero(z4), .out_parity(p4)
`endif
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit lat_chk = 1'b0;
  typedef struct { logic [7:0] y; logic [2:0] op; int t; } exp_t;
  exp_t q[$];

  function automatic logic [31:0] f(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    in_valid = v; in_op = op; in_a = a; in_b = b;
  endtask

  // One cycle: check handshake state against the model, score pops/pushes, cross the edge.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    chk("in_ready", in_ready, out_ready || q.size() < 2);
    chk("busy", busy, q.size() != 0);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("pop_empty", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("out_y", out_y, e.y);
        chk("out_op", out_op, e.op);
        if (lat_chk) chk("latency", cyc - e.t, 2);
      end
    end
    if (acc) q.push_back('{f(in_op, in_a, in_b), in_op, cyc});
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    int k = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (q.size() != 0 && k < 50) begin tick(acc); k++; end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    bit acc;
    logic [7:0] held;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_op", out_op, 0);
    @(negedge clk) rst = 1'b0;

    // truth sweep, back-to-back, latency 2
    lat_chk = 1'b1;
    for (int op = 0; op < 8; op++) begin drive(1, 3'(op), 8'hF0, 8'hCC); tick(acc); end
    drive(0, 0, 'x, 'x);
    drain();
    lat_chk = 1'b0;

    // backpressure: two accepted, third blocked, head held
    out_ready = 1'b0;
    drive(1, 3'd1, 8'h12, 8'h34); tick(acc);
    drive(1, 3'd2, 8'h56, 8'h78); tick(acc);
    drive(1, 3'd6, 8'h9A, 8'hBC); tick(acc);
    chk("third_blocked", acc, 0);
    chk("bp_valid", out_valid, 1);
    held = out_y;
    tick(acc);
    chk("bp_hold_y", out_y, held);
    out_ready = 1'b1; tick(acc);
    chk("bp_third_accepted", acc, 1);
    drain();

    // bubble collapse
    out_ready = 1'b0;
    drive(1, 3'd5, 8'h0F, 8'h3C); tick(acc);
    drive(0, 0, 'x, 'x);
    repeat (4) tick(acc);
    drive(1, 3'd3, 8'hA5, 8'hFF); tick(acc);
    chk("bubble_accept", acc, 1);
    drive(0, 0, 'x, 'x);
    drain();

    // full pop + push
    out_ready = 1'b0;
    drive(1, 3'd0, 8'h77, 8'h1F); tick(acc);
    drive(1, 3'd4, 8'h01, 8'h80); tick(acc);
    drive(1, 3'd7, 8'hE1, 8'h00); out_ready = 1'b1; tick(acc);
    chk("full_push_accept", acc, 1);
    chk("full_busy", busy, 1);
    chk("full_valid", out_valid, 1);
    drain();

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive(1, 3'd1, 8'h11, 8'h22); tick(acc);
    drive(1, 3'd2, 8'h33, 8'h44); tick(acc);
    drive(0, 0, 'x, 'x);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_y", out_y, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    drive(1, 3'd0, 8'hAA, 8'h0F); tick(acc);
    drive(0, 0, 'x, 'x);
    drain();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0)
        drive(1, 3'($urandom), 8'($urandom), 8'($urandom));
      else drive(0, 0, 'x, 'x);
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
    end
    drain();

    // WIDTH=1, STAGES=1: AND truth table with 1-cycle latency
    for (int ab = 0; ab < 4; ab++) begin
      i1_valid = 1'b1; i1_op = 3'd0; i1_a = 1'(ab >> 1); i1_b = 1'(ab);
      @(negedge clk);
      chk("w1_valid", o1_valid, 1);
      chk("w1_and", o1_y, f(3'd0, 32'(i1_a), 32'(i1_b)) & 32'h1);
    end
    i1_valid = 1'b0;
    @(negedge clk);
    chk("w1_idle", o1_valid, 0);

    // WIDTH=32, STAGES=4: XOR after exactly 4 cycles
    i4_valid = 1'b1; i4_op = 3'd2; i4_a = 32'hDEADBEEF; i4_b = 32'hFFFFFFFF;
    @(negedge clk); i4_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("w32_not_yet", o4_valid, 0);
    @(negedge clk);
    chk("w32_valid", o4_valid, 1);
    chk("w32_xor", o4_y, f(3'd2, 32'hDEADBEEF, 32'hFFFFFFFF));
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    i4_valid = 1'b1; i4_op = 3'd2; i4_a = 32'h13572468; i4_b = 32'h13572468;
    @(negedge clk); i4_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("flag_valid", o4_valid, 1);
    chk("flag_zero", z4, 1);
    chk("flag_parity", p4, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
